// File: rtl/relation_witness_scanner.sv
`default_nettype none
// ============================================================================
// Module   : relation_witness_scanner
// Purpose  : Sequential friends(A,B) checker over a loadable hates/2 fact table;
//            searches witness C one atom per clock (FIRST or COUNT mode).
// Revision : 1.0 - initial release
// ============================================================================
module relation_witness_scanner #(
  parameter int ATOM_W    = 3,
  parameter int NUM_ATOMS = 6,
  parameter int NUM_FACTS = 4,
  parameter int FADDR_W   = (NUM_FACTS > 1) ? $clog2(NUM_FACTS) : 1,
  parameter int CNT_W     = $clog2(NUM_ATOMS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fact_we,
  output logic               fact_ready,
  input  logic [FADDR_W-1:0] fact_addr,
  input  logic               fact_en,
  input  logic [ATOM_W-1:0]  fact_a,
  input  logic [ATOM_W-1:0]  fact_b,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [ATOM_W-1:0]  q_a,
  input  logic [ATOM_W-1:0]  q_b,
  input  logic               q_mode,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               r_found,
  output logic [ATOM_W-1:0]  r_witness,
  output logic [CNT_W-1:0]   r_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ATOM_W-1:0] c_last_atom = ATOM_W'(NUM_ATOMS - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = CNT_W'(NUM_ATOMS);

  state_t              r_state;
  logic [NUM_FACTS-1:0] r_fact_v;
  logic [ATOM_W-1:0]   r_fact_a [NUM_FACTS];
  logic [ATOM_W-1:0]   r_fact_b [NUM_FACTS];

  logic [ATOM_W-1:0]   r_a;
  logic [ATOM_W-1:0]   r_b;
  logic [ATOM_W-1:0]   r_c;
  logic                r_mode;
  logic [CNT_W-1:0]    r_res_cnt;
  logic                r_res_found;
  logic [ATOM_W-1:0]   r_res_wit;
  logic                r_rvalid;
  logic                r_busy;
  logic                r_idle_rdy;

  logic                w_fact_wr;
  logic                w_e_ac;
  logic                w_e_cb;
  logic                w_hit;

  // The table may only change while idle, so a running scan sees a frozen table.
  assign w_fact_wr = fact_we & r_idle_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fact_v <= '0;
      for (int i = 0; i < NUM_FACTS; i++) begin
        r_fact_a[i] <= '0;
        r_fact_b[i] <= '0;
      end
    end else if (w_fact_wr) begin
      for (int i = 0; i < NUM_FACTS; i++) begin
        if (fact_addr == FADDR_W'(i)) begin
          r_fact_v[i] <= fact_en;
          r_fact_a[i] <= fact_a;
          r_fact_b[i] <= fact_b;
        end
      end
    end
  end

  // enemies() is symmetric, so each entry is matched in both orientations.
  always_comb begin
    w_e_ac = 1'b0;
    w_e_cb = 1'b0;
    for (int i = 0; i < NUM_FACTS; i++) begin
      if (r_fact_v[i]) begin
        if ((r_fact_a[i] == r_a && r_fact_b[i] == r_c) ||
            (r_fact_a[i] == r_c && r_fact_b[i] == r_a))
          w_e_ac = 1'b1;
        if ((r_fact_a[i] == r_c && r_fact_b[i] == r_b) ||
            (r_fact_a[i] == r_b && r_fact_b[i] == r_c))
          w_e_cb = 1'b1;
      end
    end
  end

  assign w_hit = w_e_ac & w_e_cb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_mode      <= 1'b0;
      r_res_cnt   <= '0;
      r_res_found <= 1'b0;
      r_res_wit   <= '0;
      r_rvalid    <= 1'b0;
      r_busy      <= 1'b0;
      r_idle_rdy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (q_valid && r_idle_rdy) begin
            r_a         <= q_a;
            r_b         <= q_b;
            r_mode      <= q_mode;
            r_c         <= '0;
            r_res_cnt   <= '0;
            r_res_found <= 1'b0;
            r_res_wit   <= '0;
            r_busy      <= 1'b1;
            r_idle_rdy  <= 1'b0;
            r_state     <= (q_a == q_b) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            if (r_res_cnt != c_cnt_max)
              r_res_cnt <= r_res_cnt + CNT_W'(1);
            if (!r_res_found) begin
              r_res_found <= 1'b1;
              r_res_wit   <= r_c;
            end
          end
          if ((w_hit && !r_mode) || (r_c == c_last_atom))
            r_state <= S_DONE;
          else
            r_c <= r_c + ATOM_W'(1);
        end
        S_DONE: begin
          // First DONE cycle raises r_valid; the handshake is taken once it is visible.
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
          end else if (r_ready) begin
            r_rvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_idle_rdy <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rvalid   <= 1'b0;
          r_busy     <= 1'b0;
          r_idle_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign fact_ready = r_idle_rdy;
  assign q_ready    = r_idle_rdy;
  assign busy       = r_busy;
  assign r_valid    = r_rvalid;
  assign r_found    = r_res_found;
  assign r_witness  = r_res_wit;
  assign r_count    = r_res_cnt;

endmodule
`default_nettype wire

// File: tb/tb_relation_witness_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_relation_witness_scanner
// Purpose  : Directed bench with reference model and result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relation_witness_scanner;
  localparam int ATOM_W    = 3;
  localparam int NUM_ATOMS = 6;
  localparam int NUM_FACTS = 4;
  localparam int FADDR_W   = 2;
  localparam int CNT_W     = 3;

  logic               clk;
  logic               rst_n;
  logic               fact_we;
  logic               fact_ready;
  logic [FADDR_W-1:0] fact_addr;
  logic               fact_en;
  logic [ATOM_W-1:0]  fact_a;
  logic [ATOM_W-1:0]  fact_b;
  logic               q_valid;
  logic               q_ready;
  logic [ATOM_W-1:0]  q_a;
  logic [ATOM_W-1:0]  q_b;
  logic               q_mode;
  logic               r_valid;
  logic               r_ready;
  logic               r_found;
  logic [ATOM_W-1:0]  r_witness;
  logic [CNT_W-1:0]   r_count;
  logic               busy;

  relation_witness_scanner #(
    .ATOM_W(ATOM_W), .NUM_ATOMS(NUM_ATOMS), .NUM_FACTS(NUM_FACTS),
    .FADDR_W(FADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fact_we(fact_we), .fact_ready(fact_ready), .fact_addr(fact_addr),
    .fact_en(fact_en), .fact_a(fact_a), .fact_b(fact_b),
    .q_valid(q_valid), .q_ready(q_ready), .q_a(q_a), .q_b(q_b), .q_mode(q_mode),
    .r_valid(r_valid), .r_ready(r_ready), .r_found(r_found),
    .r_witness(r_witness), .r_count(r_count), .busy(busy)
  );

  typedef struct {
    logic              found;
    logic [ATOM_W-1:0] wit;
    logic [CNT_W-1:0]  cnt;
    int                lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic              mv [NUM_FACTS];
  logic [ATOM_W-1:0] ma [NUM_FACTS];
  logic [ATOM_W-1:0] mb [NUM_FACTS];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic enem(input logic [ATOM_W-1:0] x, input logic [ATOM_W-1:0] y);
    for (int i = 0; i < NUM_FACTS; i++)
      if (mv[i] && ((ma[i] == x && mb[i] == y) || (ma[i] == y && mb[i] == x)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [ATOM_W-1:0] a, input logic [ATOM_W-1:0] b,
                                 input logic mode);
    exp_t e;
    e.found = 1'b0;
    e.wit   = '0;
    e.cnt   = '0;
    e.lat   = NUM_ATOMS + 1;
    if (a == b) begin
      e.lat = 1;
      return e;
    end
    for (int c = 0; c < NUM_ATOMS; c++) begin
      if (enem(a, ATOM_W'(c)) && enem(ATOM_W'(c), b)) begin
        e.cnt = e.cnt + 1'b1;
        if (!e.found) begin
          e.found = 1'b1;
          e.wit   = ATOM_W'(c);
          if (!mode) begin
            e.lat = c + 2;
            break;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic set_fact(input int idx, input logic en, input logic [ATOM_W-1:0] a,
                          input logic [ATOM_W-1:0] b);
    @(negedge clk);
    fact_we = 1'b1; fact_addr = FADDR_W'(idx); fact_en = en; fact_a = a; fact_b = b;
    @(posedge clk);
    #1 fact_we = 1'b0;
    mv[idx] = en; ma[idx] = a; mb[idx] = b;
  endtask

  // Accept edge is cycle 0; latency = rising edges until r_valid is seen.
  task automatic issue(input string tag, input logic [ATOM_W-1:0] a,
                       input logic [ATOM_W-1:0] b, input logic mode);
    exp_t e;
    int   n;
    sb.push_back(model(a, b, mode));
    @(negedge clk);
    chk({tag, "_q_ready"}, 32'(q_ready), 1);
    q_valid = 1'b1; q_a = a; q_b = b; q_mode = mode;
    @(posedge clk);
    #1 q_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    n = 0;
    while (!r_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(n), 32'(e.lat));
    chk({tag, "_found"}, 32'(r_found), 32'(e.found));
    chk({tag, "_witness"}, 32'(r_witness), 32'(e.wit));
    chk({tag, "_count"}, 32'(r_count), 32'(e.cnt));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    r_ready = 1'b1;
    @(posedge clk);
    #1 r_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(r_valid), 0);
    chk({tag, "_rel_busy"}, 32'(busy), 0);
    chk({tag, "_rel_q_ready"}, 32'(q_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; fact_we = 1'b0; fact_addr = '0; fact_en = 1'b0; fact_a = '0; fact_b = '0;
    q_valid = 1'b0; q_a = '0; q_b = '0; q_mode = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < NUM_FACTS; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_r_found", 32'(r_found), 0);
    chk("rst_r_witness", 32'(r_witness), 0);
    chk("rst_r_count", 32'(r_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fact_ready", 32'(fact_ready), 1);
    chk("rst_q_ready", 32'(q_ready), 1);
    @(negedge clk) rst_n = 1'b1;

    // T1: hates(0,1), hates(1,2); FIRST query finds witness 1
    set_fact(0, 1'b1, 3'd0, 3'd1);
    set_fact(1, 1'b1, 3'd1, 3'd2);
    issue("t1", 3'd0, 3'd2, 1'b0);

    // T4: stall the result; queries and fact writes must be refused
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      fact_we = 1'b1; fact_addr = 2'd1; fact_en = 1'b0; fact_a = 3'd5; fact_b = 3'd5;
      q_valid = 1'b1; q_a = 3'd0; q_b = 3'd0; q_mode = 1'b0;
      @(posedge clk);
      #1;
      chk("t4_hold_valid", 32'(r_valid), 1);
      chk("t4_hold_witness", 32'(r_witness), 1);
      chk("t4_hold_count", 32'(r_count), 1);
      chk("t4_hold_q_ready", 32'(q_ready), 0);
      chk("t4_hold_fact_ready", 32'(fact_ready), 0);
    end
    @(negedge clk);
    fact_we = 1'b0; q_valid = 1'b0;
    release_result("t4");

    // T2: table unchanged by the ignored write; COUNT scans all atoms
    issue("t2", 3'd0, 3'd2, 1'b1);
    release_result("t2");

    // T3: A==B short-circuits
    issue("t3", 3'd0, 3'd0, 1'b0);
    release_result("t3");

    // T5: second witness through hates(3,0), hates(2,3)
    set_fact(2, 1'b1, 3'd3, 3'd0);
    set_fact(3, 1'b1, 3'd2, 3'd3);
    issue("t5", 3'd0, 3'd2, 1'b1);
    release_result("t5");

    // FIRST mode on the same table still stops at the lowest witness
    issue("t5f", 3'd2, 3'd0, 1'b0);
    release_result("t5f");

    // T6: reset mid-scan clears table and aborts the query
    @(negedge clk);
    q_valid = 1'b1; q_a = 3'd0; q_b = 3'd2; q_mode = 1'b1;
    @(posedge clk);
    #1 q_valid = 1'b0;
    @(posedge clk);
    #1 chk("t6_scan_busy", 32'(busy), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(r_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_q_ready", 32'(q_ready), 1);
    for (int i = 0; i < NUM_FACTS; i++) mv[i] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    issue("t6", 3'd0, 3'd2, 1'b0);
    release_result("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
